// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//   Parametrised universal datapath register. It can hold, parallel-load,
//   shift or rotate in either direction, increment and decrement. It has
//   serial in/out, a carry/borrow flag and a zero flag.
//
// Parameters
//   WIDTH      register width in bits (>= 2)
//   RESET_VAL  value of q after async reset or synchronous clear
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (q=RESET_VAL, sout=0, co=0)
//   clr_n    synchronous active-low clear, same effect as reset; beats en_n
//   en_n     active-low enable; high holds q, sout and co
//   mode     operation select (see mode_e)
//   d        parallel load data
//   sin_l    serial bit entering the LSB on shift-left
//   sin_r    serial bit entering the MSB on shift-right
//   q        registered data output
//   sout     registered; last bit shifted or rotated out
//   co       registered; carry (inc) or borrow (dec) of the last count
//   zero     combinational; high when q is all zeros
// -----------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_n,
  input  logic             en_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             co,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROTL = 3'b100,
    MODE_ROTR = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_co;

  mode_e            w_mode;
  logic             w_all_ones;
  logic             w_all_zero;

  assign w_mode     = mode_e'(mode);
  assign w_all_ones = &r_q;
  assign w_all_zero = ~|r_q;

  // NOTE: state registers use non-blocking assignments so that every branch
  // reads the pre-edge value of r_q. For example, sout takes the old MSB while
  // q shifts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q    <= RESET_VAL;
      r_sout <= 1'b0;
      r_co   <= 1'b0;
    end else if (!clr_n) begin
      r_q    <= RESET_VAL;
      r_sout <= 1'b0;
      r_co   <= 1'b0;
    end else if (!en_n) begin
      // Flags are only touched by their own mode group and hold otherwise.
      case (w_mode)
        MODE_HOLD: ;
        MODE_LOAD: r_q <= d;
        MODE_SHL: begin
          r_q    <= {r_q[WIDTH-2:0], sin_l};
          r_sout <= r_q[WIDTH-1];
        end
        MODE_SHR: begin
          r_q    <= {sin_r, r_q[WIDTH-1:1]};
          r_sout <= r_q[0];
        end
        MODE_ROTL: begin
          r_q    <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          r_sout <= r_q[WIDTH-1];
        end
        MODE_ROTR: begin
          r_q    <= {r_q[0], r_q[WIDTH-1:1]};
          r_sout <= r_q[0];
        end
        MODE_INC: begin
          r_q  <= r_q + 1'b1;
          r_co <= w_all_ones;  // wrap from all-ones to zero
        end
        MODE_DEC: begin
          r_q  <= r_q - 1'b1;
          r_co <= w_all_zero;  // wrap from zero to all-ones
        end
        default: ;
      endcase
    end
  end

  assign q    = r_q;
  assign sout = r_sout;
  assign co   = r_co;
  assign zero = w_all_zero;

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
//   Drives two univ_shift_reg instances (RESET_VAL 0x00 and 0x3C) from shared
//   inputs. Outputs are compared with an arithmetic reference model. Inputs
//   change on the falling edge and outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clr_n = 1'b1;
  logic         en_n = 1'b1;
  logic [2:0]   mode = 3'd0;
  logic [W-1:0] d = '0;
  logic         sin_l = 1'b0;
  logic         sin_r = 1'b0;

  logic [W-1:0] q0, q1;
  logic         sout0, sout1, co0, co1, zero0, zero1;

  int total = 0;
  int bad   = 0;

  // reference model state, one entry per instance
  int m_q[2];
  int m_sout[2];
  int m_co[2];
  int m_rv[2] = '{0, 'h3C};

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .clr_n(clr_n), .en_n(en_n), .mode(mode),
    .d(d), .sin_l(sin_l), .sin_r(sin_r),
    .q(q0), .sout(sout0), .co(co0), .zero(zero0)
  );

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h3C)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .clr_n(clr_n), .en_n(en_n), .mode(mode),
    .d(d), .sin_l(sin_l), .sin_r(sin_r),
    .q(q1), .sout(sout1), .co(co1), .zero(zero1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i] = m_rv[i];
      m_sout[i] = 0;
      m_co[i] = 0;
    end
  endtask

  // One rising edge seen through the rules of the mode table, using plain arithmetic.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!clr_n) begin
        m_q[i] = m_rv[i]; m_sout[i] = 0; m_co[i] = 0;
      end else if (!en_n) begin
        case (int'(mode))
          1: m_q[i] = int'(d);
          2: begin m_sout[i] = m_q[i] / (MOD/2); m_q[i] = (m_q[i]*2) % MOD + int'(sin_l); end
          3: begin m_sout[i] = m_q[i] % 2; m_q[i] = m_q[i]/2 + int'(sin_r)*(MOD/2); end
          4: begin m_sout[i] = m_q[i] / (MOD/2); m_q[i] = (m_q[i]*2) % MOD + m_q[i]/(MOD/2); end
          5: begin m_sout[i] = m_q[i] % 2; m_q[i] = m_q[i]/2 + (m_q[i]%2)*(MOD/2); end
          6: begin m_co[i] = (m_q[i] == MOD-1) ? 1 : 0; m_q[i] = (m_q[i] + 1) % MOD; end
          7: begin m_co[i] = (m_q[i] == 0) ? 1 : 0; m_q[i] = (m_q[i] + MOD - 1) % MOD; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q0"},    32'(q0),    32'(m_q[0]));
    check({tag, "_sout0"}, 32'(sout0), 32'(m_sout[0]));
    check({tag, "_co0"},   32'(co0),   32'(m_co[0]));
    check({tag, "_zero0"}, 32'(zero0), 32'(m_q[0] == 0));
    check({tag, "_q1"},    32'(q1),    32'(m_q[1]));
    check({tag, "_sout1"}, 32'(sout1), 32'(m_sout[1]));
    check({tag, "_co1"},   32'(co1),   32'(m_co[1]));
    check({tag, "_zero1"}, 32'(zero1), 32'(m_q[1] == 0));
  endtask

  // Called at a falling edge. It applies inputs, takes one rising edge, and
  // checks at the next falling edge.
  task automatic step(input string tag, input logic c, input logic e, input logic [2:0] m,
                      input logic [W-1:0] dd, input logic sl, input logic sr);
    clr_n = c; en_n = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between edges; an edge occurs while it is held.
  task automatic pulse_reset(input string tag, input logic also_clr);
    #2;
    if (also_clr) clr_n = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    check_all({tag, "_held"});
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    @(negedge clk);
    pulse_reset("reset", 1'b0);
    check("reset_q0_const", 32'(q0), 32'h00);
    check("reset_q1_const", 32'(q1), 32'h3C);
    check("reset_zero1_const", 32'(zero1), 32'h0);

    // load and hold
    step("load", 1, 0, 3'b001, 8'hA5, 0, 0);
    check("load_q_const", 32'(q0), 32'hA5);
    for (int m = 0; m < 8; m++)
      step("hold", 1, 1, 3'(m), 8'(m * 37), m[0], m[1]);
    check("hold_q_const", 32'(q0), 32'hA5);

    // shifts
    step("shl", 1, 0, 3'b010, 8'h00, 1, 1);
    check("shl_q_const", 32'(q0), 32'h4B);
    check("shl_sout_const", 32'(sout0), 32'h1);
    step("shr", 1, 0, 3'b011, 8'hFF, 1, 0);
    check("shr_q_const", 32'(q0), 32'h25);
    check("shr_sout_const", 32'(sout0), 32'h1);

    // rotates with serial inputs toggling
    step("ld81", 1, 0, 3'b001, 8'h81, 0, 0);
    step("rotl", 1, 0, 3'b100, 8'h00, 0, 1);
    check("rotl_q_const", 32'(q0), 32'h03);
    step("rotr", 1, 0, 3'b101, 8'h00, 1, 0);
    check("rotr_q_const", 32'(q0), 32'h81);
    check("rotr_sout_const", 32'(sout0), 32'h1);

    // counting boundaries
    step("ldff", 1, 0, 3'b001, 8'hFF, 0, 0);
    step("inc_wrap", 1, 0, 3'b110, 8'h00, 0, 0);
    check("inc_wrap_q_const", 32'(q0), 32'h00);
    check("inc_wrap_co_const", 32'(co0), 32'h1);
    check("inc_wrap_zero_const", 32'(zero0), 32'h1);
    step("dec_wrap", 1, 0, 3'b111, 8'h00, 0, 0);
    check("dec_wrap_q_const", 32'(q0), 32'hFF);
    check("dec_wrap_co_const", 32'(co0), 32'h1);
    step("ld10", 1, 0, 3'b001, 8'h10, 0, 0);
    step("inc", 1, 0, 3'b110, 8'h00, 0, 0);
    check("inc_q_const", 32'(q0), 32'h11);
    check("inc_co_const", 32'(co0), 32'h0);
    step("ld_co", 1, 0, 3'b001, 8'h22, 0, 0);
    check("ld_co_const", 32'(co0), 32'h0);

    // clear priority
    step("ld55", 1, 0, 3'b001, 8'h55, 0, 0);
    step("clr_en", 0, 0, 3'b110, 8'h00, 0, 0);
    check("clr_q0_const", 32'(q0), 32'h00);
    check("clr_q1_const", 32'(q1), 32'h3C);
    step("ld55b", 1, 0, 3'b001, 8'h55, 0, 0);
    step("clr_dis", 0, 1, 3'b010, 8'h00, 1, 1);

    // reset in the middle of an inc run, then resume from RESET_VAL
    step("ld7e", 1, 0, 3'b001, 8'h7E, 0, 0);
    step("inc_a", 1, 0, 3'b110, 8'h00, 0, 0);
    step("inc_b", 1, 0, 3'b110, 8'h00, 0, 0);
    pulse_reset("rst_mid", 1'b1);
    clr_n = 1'b1;
    step("inc_resume", 1, 0, 3'b110, 8'h00, 0, 0);
    check("inc_resume_q1_const", 32'(q1), 32'h3D);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulse_reset("rand_rst", 1'($urandom_range(0, 1)));
      end else begin
        step("rand",
             ($urandom_range(0, 15) != 0),
             ($urandom_range(0, 3) == 0),
             3'($urandom_range(0, 7)),
             ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom),
             1'($urandom), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
